// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART over its wr_en/din/wr_rdy handshake.
//   clk, rst        : single clock, synchronous active-high reset
//   push, push_data : write request and byte, accepted when !full
//   full, empty     : occupancy flags derived from the registered count
//   count           : number of occupied entries (0..DEPTH)
//   ovf             : sticky overflow flag, only built when UART_TX_FIFO_OVF_EN is defined
//   uart_wr_en      : offer strobe to the UART, high only in OFFER
//   uart_din        : byte offered, loaded only when leaving IDLE
//   uart_wr_rdy     : UART ready; the handoff edge is uart_wr_en && uart_wr_rdy
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     uart_wr_en,
  output logic [WIDTH-1:0]         uart_din,
  input  logic                     uart_wr_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // GAP always returns to IDLE so a late-falling wr_rdy cannot cause a second capture
  always_comb begin
    state_nxt = (state == IDLE)  ? (empty ? IDLE : OFFER) :
                (state == OFFER) ? (uart_wr_rdy ? GAP : OFFER) : IDLE;
  end
  always_comb begin
    uart_wr_en = state == OFFER;
    pop        = state == IDLE && !empty;
  end
  // storage is intentionally left out of reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      uart_din <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        uart_din <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end
`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (rst)              ovf <= 1'b0;
    else if (push && full) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with a loopback UART capture model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, push, uart_wr_rdy;
  logic [WIDTH-1:0] push_data;
  logic full, empty, ovf, uart_wr_en;
  logic [$clog2(DEPTH):0] count;
  logic [WIDTH-1:0] uart_din;
  logic [WIDTH-1:0] rx_q [$];
  int checks = 0;
  int errors = 0;
  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .ovf(ovf),
    .uart_wr_en(uart_wr_en), .uart_din(uart_din), .uart_wr_rdy(uart_wr_rdy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (uart_wr_en && uart_wr_rdy) rx_q.push_back(uart_din);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, rx_q.size(), n);
  endtask
  initial begin
    rst = 1'b1;
    push = 1'b0;
    push_data = '0;
    uart_wr_rdy = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_wr_en", uart_wr_en, 0);
    chk("rst_din", uart_din, 0);
    // single byte with the UART ready
    uart_wr_rdy = 1'b1;
    push = 1'b1;
    push_data = 8'hE8;
    tick(1);
    push = 1'b0;
    chk("single_empty_n1", empty, 0);
    chk("single_wr_en_n1", uart_wr_en, 0);
    tick(1);
    chk("single_wr_en_n2", uart_wr_en, 1);
    chk("single_din_n2", uart_din, 8'hE8);
    chk("single_count_n2", count, 0);
    tick(1);
    chk("single_gap_wr_en", uart_wr_en, 0);
    chk("single_rx_size", rx_q.size(), 1);
    chk("single_rx_byte", rx_q[0], 8'hE8);
    tick(1);
    rx_q.delete();
    // ordering under a stalled UART
    uart_wr_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push = 1'b1;
      push_data = WIDTH'(i);
      tick(1);
    end
    push = 1'b0;
    chk("order_count", count, 4);
    chk("order_wr_en", uart_wr_en, 1);
    chk("order_din", uart_din, 8'h01);
    tick(15);
    chk("order_stall_wr_en", uart_wr_en, 1);
    chk("order_stall_din", uart_din, 8'h01);
    chk("order_stall_rx", rx_q.size(), 0);
    uart_wr_rdy = 1'b1;
    wait_rx(5, 40, "order_rx_wait");
    tick(3);
    chk("order_rx_size", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("order_rx_%0d", i), rx_q[i], i + 1);
    chk("order_count_end", count, 0);
    chk("order_idle_wr_en", uart_wr_en, 0);
    rx_q.delete();
    // fill past full with the UART stalled
    uart_wr_rdy = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push = 1'b1;
      push_data = WIDTH'(8'h10 + i);
      tick(1);
    end
    push = 1'b0;
    chk("full_flag", full, 1);
    chk("full_count", count, DEPTH);
    chk("full_ovf", ovf, OVF_EXP);
    uart_wr_rdy = 1'b1;
    wait_rx(DEPTH + 1, 3 * DEPTH + 20, "full_rx_wait");
    tick(4);
    chk("full_rx_size", rx_q.size(), DEPTH + 1);
    for (int i = 0; i < DEPTH + 1; i++) chk($sformatf("full_rx_%0d", i), rx_q[i], 8'h10 + i);
    chk("full_drain_count", count, 0);
    chk("full_ovf_sticky", ovf, OVF_EXP);
    rx_q.delete();
    // push coinciding with the IDLE->OFFER pop at count 1
    uart_wr_rdy = 1'b0;
    push = 1'b1;
    push_data = 8'h55;
    tick(1);
    push_data = 8'hAA;
    tick(1);
    push = 1'b0;
    chk("simul_count", count, 1);
    chk("simul_wr_en", uart_wr_en, 1);
    chk("simul_din", uart_din, 8'h55);
    uart_wr_rdy = 1'b1;
    wait_rx(2, 20, "simul_rx_wait");
    chk("simul_rx_0", rx_q[0], 8'h55);
    chk("simul_rx_1", rx_q[1], 8'hAA);
    tick(3);
    chk("simul_count_end", count, 0);
    rx_q.delete();
    // pointer wrap-around over three bursts
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < DEPTH; j++) begin
        push = 1'b1;
        push_data = WIDTH'((b * DEPTH + j) ^ 8'h5A);
        tick(1);
      end
      push = 1'b0;
      wait_rx((b + 1) * DEPTH, 3 * DEPTH + 20, $sformatf("wrap_wait_%0d", b));
    end
    tick(4);
    chk("wrap_rx_size", rx_q.size(), 3 * DEPTH);
    for (int i = 0; i < 3 * DEPTH; i++) chk($sformatf("wrap_rx_%0d", i), rx_q[i], (i ^ 8'h5A) & 8'hFF);
    chk("wrap_count_end", count, 0);
    rx_q.delete();
    // reset while a byte is being offered
    uart_wr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1;
      push_data = WIDTH'(8'hC0 + i);
      tick(1);
    end
    push = 1'b0;
    chk("offer_count", count, 3);
    chk("offer_wr_en", uart_wr_en, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_wr_en", uart_wr_en, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_din", uart_din, 0);
    chk("mid_rst_ovf", ovf, 0);
    tick(3);
    chk("post_rst_wr_en", uart_wr_en, 0);
    chk("post_rst_rx", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of the `uart` block. Producers push bytes at full clock rate. The block stores them in a circular FIFO and hands them to the UART one at a time over the UART's `wr_en`/`din`/`wr_rdy` handshake. It decouples bursty software or bus writes from the serial bit rate, and an optional sticky overflow flag can be compiled in.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥2.
- `WIDTH`, 8: byte width; must match the UART `din` width.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `push`  in  1  write request; sampled on the rising edge of `clk`.
- `push_data`  in  WIDTH  byte written when `push` is accepted.
- `full`  out  1  high when `count == DEPTH`.
- `empty`  out  1  high when `count == 0`.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `ovf`  out  1  sticky overflow flag; constant 0 unless `UART_TX_FIFO_OVF_EN` is defined.
- `uart_wr_en`  out  1  drives the UART `wr_en`.
- `uart_din`  out  WIDTH  drives the UART `din`.
- `uart_wr_rdy`  in  1  driven by the UART `wr_rdy`; high when the UART can accept a byte.

## Operation
- Storage is a `DEPTH`-entry array with a write pointer and a read pointer. Pointers wrap modulo `DEPTH`.
- Push is accepted on an edge when `push && !full`. `full` is evaluated on the pre-edge value.
  - An accepted push writes `push_data` at the write pointer and increments the write pointer.
  - A push while `full` is dropped, even if a pop occurs on the same edge.
- Pop: the read pointer advances on the IDLE→OFFER transition.
- `count` updates per edge: +1 on push only, −1 on pop only, unchanged on both or neither.
- The handoff FSM has three states:
  - IDLE: `uart_wr_en=0`. If `!empty`, latch the head entry into `uart_din`, pop, and go to OFFER. Otherwise stay.
  - OFFER: `uart_wr_en=1`, `uart_din` held stable. If `uart_wr_rdy` is high on an edge, the UART has captured the byte; go to GAP. Otherwise stay, for any number of cycles.
  - GAP: `uart_wr_en=0` for exactly one cycle, then go to IDLE. This guarantees one byte per acceptance even if `wr_rdy` falls one cycle late.
- `uart_din` changes only on the IDLE→OFFER edge and on reset.
- Simultaneous push and pop on the same edge (including when `count == 1`): both take effect and `count` is unchanged.
- Reset values: `count=0`, `empty=1`, `full=0`, `ovf=0`, `uart_wr_en=0`, `uart_din=0`, pointers 0, FSM IDLE. Storage contents are not reset.
- Reset mid-operation (any state, including OFFER) clears everything on that edge. An in-flight or buffered byte is discarded, and `uart_wr_en` is low in the following cycle.

## Timing
- Push-to-offer latency: `push` high in cycle N gives `empty=0` in N+1 and `uart_wr_en=1` in N+2.
- Steady-state throughput (FIFO non-empty, UART always ready): one byte per 3 cycles (OFFER, GAP, IDLE).
- Handoff edge: the edge where `uart_wr_en && uart_wr_rdy`. The UART must not capture on any other edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined: `ovf` sets on any edge with `push && full` and stays set until `rst`.
- Not defined: `ovf` is tied to 0, no overflow logic is synthesized, and FIFO behaviour is otherwise identical.

## Test plan
- Single byte: push 0xE8 with the UART idle → `uart_wr_en` high 2 cycles later with `uart_din=0xE8`; a loopback UART receives 0xE8; `count` returns to 0.
- Ordering: push 0x01..0x05 back-to-back with `uart_wr_rdy` stalled low for 20 cycles → `count` reaches 4 with one byte in OFFER; after release the UART receives 0x01..0x05 in order with exactly one handoff per byte.
- Full/overflow: with `uart_wr_rdy=0`, push DEPTH+2 bytes 0x10.. → `full=1`, `count=DEPTH`, extra pushes dropped. With the macro, `ovf=1` sticky; without it, `ovf=0`. Draining yields only the first DEPTH+1 bytes.
- Simultaneous: at `count=1`, push 0xAA on the same edge as the IDLE→OFFER pop → `count` stays 1; the next byte offered is 0xAA.
- Wrap-around: push and drain 3×DEPTH bytes with pattern i^0x5A → all received in order, no gaps or duplicates.
- Reset in OFFER: assert `rst` one cycle while `uart_wr_en=1` and `count=3` → next cycle `uart_wr_en=0`, `count=0`, `empty=1`, `uart_din=0`, `ovf=0`.
